// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between two writeback sources.
//   The sources are req0, the main pipeline WB stage, and req1, the multi-cycle
//   unit (load miss or multiply). The winning write is registered onto
//   write_en/select/write_data with a latency of one cycle. The block also keeps
//   a 32-entry pending scoreboard for the hazard unit: a bit is set when the
//   issue stage reserves a register and cleared when that register is written back.
//
//   Build option: define WB_ARB_RR_EN for round-robin arbitration. Without it,
//   arbitration is fixed priority and req0 always wins.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   req0_valid/ready/addr/data   WB stage write request (valid/ready handshake)
//   req1_valid/ready/addr/data   multi-cycle unit write request
//   port_busy                    write port owned externally; no grants while high
//   rsv_en, rsv_addr             issue-stage reservation of a destination register
//   write_en, select, write_data registered write to the 5-to-32 decoder
//   reg_pending                  bit i = register i has an outstanding write
module regfile_wb_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              port_busy,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              write_en,
    output logic [ADDR_W-1:0] select,
    output logic [DATA_W-1:0] write_data,
    output logic [31:0]       reg_pending
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_real_write;
    logic [31:0]       w_set_mask;
    logic [31:0]       w_clr_mask;

    logic              r_write_en;
    logic [ADDR_W-1:0] r_select;
    logic [DATA_W-1:0] r_write_data;
    logic [31:0]       r_pending;

`ifdef WB_ARB_RR_EN
    // r_ptr names the requester that wins a tie: 0 = req0, 1 = req1.
    logic r_ptr;

    always_comb begin
        w_gnt0 = !port_busy && req0_valid && (!req1_valid || !r_ptr);
        w_gnt1 = !port_busy && req1_valid && (!req0_valid ||  r_ptr);
    end

    // The pointer only moves on an accept, and there are no accepts while
    // port_busy is high, so it holds its value through a busy window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_ptr <= 1'b0;
        end
    end
`else
    always_comb begin
        w_gnt0 = !port_busy && req0_valid;
        w_gnt1 = !port_busy && req1_valid && !req0_valid;
    end
`endif

    always_comb begin
        w_accept = w_gnt0 || w_gnt1;
        w_addr   = w_gnt1 ? req1_addr : req0_addr;
        w_data   = w_gnt1 ? req1_data : req0_data;
        // A write to the zero register is accepted (the requester is released)
        // but is otherwise dropped.
        w_real_write = w_accept && (w_addr != ZERO_ADDR);
    end

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (rsv_en && (rsv_addr != ZERO_ADDR)) begin
            w_set_mask = 32'd1 << rsv_addr;
        end
        if (w_real_write) begin
            w_clr_mask = 32'd1 << w_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write_en   <= 1'b0;
            r_select     <= '0;
            r_write_data <= '0;
            r_pending    <= '0;
        end else begin
            r_write_en <= w_real_write;
            if (w_real_write) begin
                r_select     <= w_addr;
                r_write_data <= w_data;
            end
            // Set is applied after clear. A register reserved in the same
            // cycle it is written back therefore stays pending, because the
            // new in-flight write has not landed yet.
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign write_en    = r_write_en;
    assign select      = r_select;
    assign write_data  = r_write_data;
    assign reg_pending = r_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [63:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [63:0] req1_data;
    logic        port_busy;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        write_en;
    logic [4:0]  select;
    logic [63:0] write_data;
    logic [31:0] reg_pending;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .port_busy   (port_busy),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .write_en    (write_en),
        .select      (select),
        .write_data  (write_data),
        .reg_pending (reg_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        port_busy  = 0; rsv_en = 0; rsv_addr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (write_en !== 1'b0 || select !== 5'd0 || write_data !== 64'd0 || reg_pending !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: we=%b sel=%0d data=%h pend=%h, want 0", write_en, select, write_data, reg_pending);
        end
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: r0=%b r1=%b, want 0 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req0_valid = 1; req0_addr = 5; req0_data = 64'hDEAD;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_ready: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0;
        total++;
        if (write_en !== 1'b1 || select !== 5'd5 || write_data !== 64'hDEAD) begin
            bad++;
            $display("FAIL single_write: we=%b sel=%0d data=%h, want 1 5 dead", write_en, select, write_data);
        end
        tick();
        total++;
        if (write_en !== 1'b0 || select !== 5'd5 || write_data !== 64'hDEAD) begin
            bad++;
            $display("FAIL single_after: we=%b sel=%0d data=%h, want 0 5 dead", write_en, select, write_data);
        end
    endtask

    task automatic test_back_to_back();
        logic exp0 [4];
`ifdef WB_ARB_RR_EN
        exp0 = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp0 = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        req0_valid = 1; req0_addr = 1; req0_data = 64'h1111;
        req1_valid = 1; req1_addr = 2; req1_data = 64'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (req0_ready !== exp0[i] || req1_ready !== !exp0[i]) begin
                bad++;
                $display("FAIL b2b_grant[%0d]: r0=%b r1=%b, want r0=%b", i, req0_ready, req1_ready, exp0[i]);
            end
            tick();
            total++;
            if (write_en !== 1'b1 || select !== (exp0[i] ? 5'd1 : 5'd2)
                || write_data !== (exp0[i] ? 64'h1111 : 64'h2222)) begin
                bad++;
                $display("FAIL b2b_write[%0d]: we=%b sel=%0d data=%h, want grant r0=%b", i, write_en, select, write_data, exp0[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_port_busy();
        do_reset();
        req0_valid = 1; req0_addr = 3; req0_data = 64'h3333;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL busy_pre: r0=%b, want 1", req0_ready);
        end
        tick();
        req1_valid = 1; req1_addr = 4; req1_data = 64'h4444;
        port_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL busy_ready[%0d]: r0=%b r1=%b, want 0 0", i, req0_ready, req1_ready);
            end
            tick();
            total++;
            if (write_en !== 1'b0) begin
                bad++;
                $display("FAIL busy_we[%0d]: we=%b, want 0", i, write_en);
            end
        end
        port_busy = 0;
        #1;
        total++;
`ifdef WB_ARB_RR_EN
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL busy_release: r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
        end
`else
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_release: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
        end
`endif
        tick();
        idle_inputs();
        total++;
`ifdef WB_ARB_RR_EN
        if (write_en !== 1'b1 || select !== 5'd4) begin
            bad++;
            $display("FAIL busy_write: we=%b sel=%0d, want 1 4", write_en, select);
        end
`else
        if (write_en !== 1'b1 || select !== 5'd3) begin
            bad++;
            $display("FAIL busy_write: we=%b sel=%0d, want 1 3", write_en, select);
        end
`endif
    endtask

    task automatic test_scoreboard();
        do_reset();
        rsv_en = 1; rsv_addr = 7;
        tick();
        total++;
        if (reg_pending !== 32'h0000_0080) begin
            bad++;
            $display("FAIL sb_reserve7: pend=%h, want 00000080", reg_pending);
        end
        rsv_addr = 9;
        tick();
        rsv_en = 0;
        total++;
        if (reg_pending !== 32'h0000_0280) begin
            bad++;
            $display("FAIL sb_reserve9: pend=%h, want 00000280", reg_pending);
        end
        req0_valid = 1; req0_addr = 7; req0_data = 64'h77;
        tick();
        total++;
        if (reg_pending !== 32'h0000_0200) begin
            bad++;
            $display("FAIL sb_clear7: pend=%h, want 00000200", reg_pending);
        end
        rsv_en = 1; rsv_addr = 7;
        tick();
        total++;
        if (reg_pending !== 32'h0000_0280) begin
            bad++;
            $display("FAIL sb_same_cycle: pend=%h, want 00000280", reg_pending);
        end
        rsv_addr = 9; req0_addr = 12;
        tick();
        idle_inputs();
        total++;
        if (reg_pending !== 32'h0000_0280) begin
            bad++;
            $display("FAIL sb_idempotent: pend=%h, want 00000280", reg_pending);
        end
    endtask

    task automatic test_zero_reg();
        req1_valid = 1; req1_addr = 31; req1_data = 64'hBAD;
        #1;
        total++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            bad++;
            $display("FAIL zero_ready: r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
        end
        tick();
        idle_inputs();
        total++;
        if (write_en !== 1'b0 || reg_pending !== 32'h0000_0280) begin
            bad++;
            $display("FAIL zero_write: we=%b pend=%h, want 0 00000280", write_en, reg_pending);
        end
        rsv_en = 1; rsv_addr = 31;
        tick();
        rsv_en = 0;
        total++;
        if (reg_pending !== 32'h0000_0280) begin
            bad++;
            $display("FAIL zero_reserve: pend=%h, want 00000280", reg_pending);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req0_valid = 1; req0_addr = 10; req0_data = 64'hA0;
        rsv_en = 1; rsv_addr = 11;
        tick();
        req0_addr = 12; req0_data = 64'hC0;
        total++;
        if (write_en !== 1'b1 || reg_pending !== 32'h0000_0800) begin
            bad++;
            $display("FAIL midrst_pre: we=%b pend=%h, want 1 00000800", write_en, reg_pending);
        end
        #1;
        reset_n = 0;
        #1;
        total++;
        if (write_en !== 1'b0 || select !== 5'd0 || write_data !== 64'd0 || reg_pending !== 32'd0) begin
            bad++;
            $display("FAIL midrst_async: we=%b sel=%0d data=%h pend=%h, want 0", write_en, select, write_data, reg_pending);
        end
        idle_inputs();
        tick();
        reset_n = 1;
        tick();
        total++;
        if (write_en !== 1'b0) begin
            bad++;
            $display("FAIL midrst_release: we=%b, want 0", write_en);
        end
        req1_valid = 1; req1_addr = 13; req1_data = 64'hD0;
        tick();
        idle_inputs();
        total++;
        if (write_en !== 1'b1 || select !== 5'd13 || write_data !== 64'hD0) begin
            bad++;
            $display("FAIL midrst_next: we=%b sel=%0d data=%h, want 1 13 d0", write_en, select, write_data);
        end
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_port_busy();
        test_scoreboard();
        test_zero_reg();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
